csa_accum_resolve: RTL and testbench



---
 rtl/csa_acc_pkg.sv | 12 +
 rtl/csa_accum_resolve_if.sv | 29 ++
 rtl/cpa_chunk.sv | 12 +
 rtl/csa_3to2.sv | 20 ++
 rtl/csa_accum_resolve.sv | 101 ++++++++++
 tb/tb_csa_accum_resolve.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and elaboration helpers for the carry-save accumulator
// and its carry-propagate resolve stage.
package csa_acc_pkg;

    typedef enum logic [1:0] {ACC, RESOLVE, OUT} acc_state_t;

    // The resolve adder walks K in whole W-bit chunks, so W must divide K.
    function automatic bit k_w_ok(input int k, input int w);
        return (w > 0) && (k >= w) && ((k % w) == 0);
    endfunction

endpackage

// File: rtl/csa_accum_resolve_if.sv
// Operand stream in, resolved result out, plus status/debug observation.
interface csa_accum_resolve_if
    import csa_acc_pkg::*;
#(
    parameter int K = 64
);
    // Both channels use strict valid/ready: a beat moves on a rising edge where
    // valid && ready; a source holding valid keeps its payload stable until then,
    // and ready may depend on state but never on the same-cycle valid.
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_sum;
    logic         busy;
    acc_state_t   dbg_state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, busy, dbg_state
    );
endinterface

// File: rtl/cpa_chunk.sv
// W-bit ripple adder slice with carry in/out, time-shared across chunks.
module cpa_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor; carry word is pre-shifted and
// drops the MSB carry so sum + carry == a + b + c mod 2^K.
module csa_3to2 #(
    parameter int N = 3,
    parameter int K = 64
) (
    input  logic [N-1:0][K-1:0] ops,
    output logic [K-1:0]        sum,
    output logic [K-1:0]        carry
);
    if (N != 3) begin : g_bad_n
        $error("csa_3to2 only compresses exactly three operands");
    end

    logic [K-1:0] maj;

    assign sum   = ops[0] ^ ops[1] ^ ops[2];
    assign maj   = (ops[0] & ops[1]) | (ops[0] & ops[2]) | (ops[1] & ops[2]);
    assign carry = {maj[K-2:0], 1'b0};
endmodule

// File: rtl/csa_accum_resolve.sv
// Accumulates a batch in redundant (S, C) form one beat per cycle, then
// resolves S + C chunk by chunk into a binary result held until taken.
module csa_accum_resolve
    import csa_acc_pkg::*;
#(
    parameter int K = 64,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_accum_resolve_if.slave   bus
);
    localparam int NCH = K / W;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    if (!k_w_ok(K, W)) begin : g_bad_kw
        $error("csa_accum_resolve: K must be a non-zero multiple of W");
    end

    acc_state_t    state_q;
    logic [K-1:0]  s_q, c_q, r_q;
    logic          cy_q;
    logic [IW-1:0] idx_q;

    logic [2:0][K-1:0] csa_ops;
    logic [K-1:0]      csa_sum, csa_carry;
    logic [W-1:0]      chunk_s, chunk_c, chunk_sum;
    logic              chunk_co;
    logic              accept, deliver, last_chunk;

    assign csa_ops = {bus.in_data, s_q, c_q};

    csa_3to2 #(.N(3), .K(K)) u_csa (
        .ops   (csa_ops),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    assign chunk_s = s_q[idx_q*W +: W];
    assign chunk_c = c_q[idx_q*W +: W];

    cpa_chunk #(.W(W)) u_cpa (
        .a  (chunk_s),
        .b  (chunk_c),
        .ci (cy_q),
        .s  (chunk_sum),
        .co (chunk_co)
    );

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == OUT);
    assign bus.busy      = (state_q != ACC);
    assign bus.out_sum   = r_q;
    assign bus.dbg_state = state_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign deliver    = bus.out_valid && bus.out_ready;
    assign last_chunk = (idx_q == IW'(NCH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            s_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        s_q <= csa_sum;
                        c_q <= csa_carry;
                        if (bus.in_last) begin
                            state_q <= RESOLVE;
                            idx_q   <= '0;
                            cy_q    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_q[idx_q*W +: W] <= chunk_sum;
                    cy_q              <= chunk_co;
                    idx_q             <= idx_q + 1'b1;
                    // Carry out of the top chunk is the mod-2^K overflow and is dropped.
                    if (last_chunk) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (deliver) begin
                        s_q     <= '0;
                        c_q     <= '0;
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_resolve.sv
// Directed bench for csa_accum_resolve: batch sums, latency, backpressure
// and asynchronous reset, with hand-computed expected values.
module tb_csa_accum_resolve;
    import csa_acc_pkg::*;

    localparam int K = 64;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    csa_accum_resolve_if #(.K(K)) bus ();

    csa_accum_resolve #(.K(K), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [K-1:0] d, input logic l);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        chk("in_ready_before_beat", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the edge that accepted in_last.
    task automatic wait_result(input string tag, input logic [K-1:0] exp_sum);
        int lat;
        bit ready_low;
        lat       = 0;
        ready_low = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ready_low = 1'b0;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_ready_low_in_resolve"}, {63'd0, ready_low}, 64'd1);
        chk({tag, "_sum"}, bus.out_sum, exp_sum);
    endtask

    task automatic expect_idle_after_take(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid_cleared"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_in_ready_back"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        bit stable;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_out_sum", bus.out_sum, 64'd0);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_state", 64'(bus.dbg_state), 64'(ACC));
        @(negedge clk);
        rst_n = 1'b1;

        // 1 + 2 + 3, beats back to back
        beat(64'd1, 1'b0);
        beat(64'd2, 1'b0);
        beat(64'd3, 1'b1);
        wait_result("b123", 64'd6);
        expect_idle_after_take("b123");

        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_result("single_ones", 64'hFFFF_FFFF_FFFF_FFFF);
        expect_idle_after_take("single_ones");

        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        beat(64'd1, 1'b0);
        beat(64'd5, 1'b1);
        wait_result("wrap", 64'd5);
        expect_idle_after_take("wrap");

        beat(64'h0000_0000_0000_FFFF, 1'b0);
        beat(64'd1, 1'b1);
        wait_result("chunk_carry", 64'h0000_0000_0001_0000);
        expect_idle_after_take("chunk_carry");

        beat(64'h1234_0000_0000_0001, 1'b0);
        beat(64'h0000_FFFF_FFFF_FFFF, 1'b1);
        wait_result("mixed", 64'h1235_0000_0000_0000);
        expect_idle_after_take("mixed");

        // Backpressure: result 2 + 3 held while a new beat is offered
        bus.out_ready = 1'b0;
        beat(64'd2, 1'b0);
        beat(64'd3, 1'b1);
        wait_result("bp", 64'd5);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'd99;
        bus.in_last  = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_sum !== 64'd5 || bus.busy !== 1'b1) stable = 1'b0;
        end
        chk("bp_held_stable", {63'd0, stable}, 64'd1);
        chk("bp_state_out", 64'(bus.dbg_state), 64'(OUT));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_taken", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        beat(64'd4, 1'b0);
        beat(64'd4, 1'b1);
        wait_result("after_bp", 64'd8);
        expect_idle_after_take("after_bp");

        // Asynchronous reset in the middle of a batch
        beat(64'd10, 1'b0);
        beat(64'd20, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_sum", bus.out_sum, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beat(64'd7, 1'b1);
        wait_result("after_rst", 64'd7);
        expect_idle_after_take("after_rst");

        // Reset while resolving discards the pending result
        beat(64'd100, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resolve_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_resolve_out_sum", bus.out_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(64'd9, 1'b1);
        wait_result("after_rst2", 64'd9);
        expect_idle_after_take("after_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
